mini_cpu_sequencer: RTL
=======================

// Module: mini_cpu_sequencer
// PURPOSE
//  Program sequencer for the 4-bit mini-CPU datapath. Holds a small instruction store loaded by the host,
//  fetches/decodes instructions, resolves control flow (JMP/JZ/NOP/HALT) locally, and drives the datapath
//  opcode/addr/data/write-enable pins for HOLD_CYCLES cycles per datapath instruction. Sits between host pins and datapath.
// PARAMETERS
//  HOLD_CYCLES  3   cycles each datapath instruction is held on dp_* outputs (>=2; datapath needs IDLE->op)
//  PROG_DEPTH   16  instruction store entries; pc width = 4 (fixed)
//  INSTR_W      12  instruction width: [11:8] opcode, [7:4] addr/target, [3:0] data
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-high
//  prog_we     in   1   host write strobe to instruction store (honoured only when busy=0)
//  prog_addr   in   4   host write address
//  prog_wdata  in   12  host write data
//  start       in   1   pulse: begin execution at pc=0 (from IDLE or HALTED)
//  halt_req    in   1   request stop after current instruction
//  acc_in      in   4   datapath accumulator (JZ condition)
//  dp_opcode   out  4   datapath opcode; 4'hF = idle
//  dp_addr     out  4   datapath memory address
//  dp_data     out  4   datapath immediate data
//  dp_we       out  1   datapath write enable (1 only during STORE)
//  pc          out  4   current program counter
//  busy        out  1   1 in FETCH/DECODE/EXEC
//  halted      out  1   1 in HALTED
// BEHAVIOUR
//  Clocking: clk only; rst is synchronous active-high. Reset (also mid-operation) -> state IDLE, pc=0, busy=0, halted=0,
//   dp_opcode=4'hF, dp_addr=0, dp_data=0, dp_we=0. Instruction store contents are not cleared.
//  Opcodes to datapath: 0000 ADD, 0001 SUB, 0010 STORE, 0011 LOAD, 0101 AND, 0110 OR, 0111 XOR, 1000 NOT, 1001 SHL, 1010 SHR.
//  Local opcodes: 1100 JMP (pc<=addr), 1101 JZ (acc_in==0 ? pc<=addr : pc+1), 1110 NOP, 1111 HALT. 0100/1011 treated as NOP.
//  States: IDLE, FETCH, DECODE, EXEC, HALTED.
//   IDLE:   start=1 & halt_req=0 -> pc<=0, FETCH. halt_req has priority (stay IDLE).
//   FETCH:  registered read instr<=mem[pc]; -> DECODE (1 cycle).
//   DECODE: JMP/JZ/NOP -> update pc, FETCH; HALT -> HALTED; datapath op -> load dp_* regs, cnt<=0, EXEC.
//   EXEC:   dp_* held constant exactly HOLD_CYCLES cycles; dp_we=1 throughout iff STORE. On last cycle
//           dp_opcode<=4'hF, dp_we<=0, pc<=pc+1, -> FETCH (HALTED if halt_req latched).
//   HALTED: halted=1; start -> pc<=0, FETCH. halt_req ignored.
//  Latency: datapath instr = 2+HOLD_CYCLES cycles (5 default); JMP/JZ/NOP = 2 cycles.
//  pc arithmetic mod 16: 15+1 wraps to 0. Jump target = instr[7:4] verbatim.
//  halt_req in FETCH/DECODE/EXEC latched in sticky flag; honoured at next instruction boundary; cleared on start.
//  start while busy ignored. prog_we while busy ignored (store unchanged). prog_we and start same cycle in IDLE:
//   write occurs, execution starts, FETCH reads new contents (write precedes first read by 1 cycle).
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: extra inputs step_mode(1), step(1). With step_mode=1, EXEC completion and
//   JMP/JZ/NOP resolution go to IDLE-like PAUSE state (busy=0, pc holds); step pulse -> FETCH. start still restarts at 0.
//  Not defined: ports absent, continuous execution only.
// STRUCTURE
//  Package mini_cpu_pkg: opcode localparams, dp idle opcode 4'hF, state encoding, instr field bit positions.
//  Sub-module mini_cpu_prog_mem: PROG_DEPTH x INSTR_W, sync write, registered read.
// TESTING
//  1 Assert rst 2 cycles -> dp_opcode=4'hF, dp_we=0, pc=0, busy=0, halted=0.
//  2 mem[0]=12'h003 (ADD 3), mem[1]=12'hF00; start -> dp_opcode=0000,dp_data=3 cycles 3-5 after start; halted=1 at cycle 8.
//  3 mem[0]=12'hD50, acc_in=0 -> pc=5 two cycles after start; repeat acc_in=4'h2 -> pc=1.
//  4 mem[15]=12'hE00, mem[0]=12'hF00, JMP at 0 replaced by mem[0]=12'hCF0 first -> pc wraps 15->0.
//  5 mem[0]=12'h2A0 (STORE addr A); halt_req during EXEC cycle 1 -> dp_we=1 full 3 cycles, then HALTED, pc=1.
//  6 prog_we to addr 0 while busy -> mem unchanged; SEQ_SINGLE_STEP_EN: step_mode=1 -> one instr per step pulse.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini-CPU program sequencer: opcodes, instruction
// field positions, sequencer state encoding and a datapath-opcode classifier.
package mini_cpu_pkg;

   localparam int PC_W = 4;

   localparam int OP_MSB   = 11;
   localparam int OP_LSB   = 8;
   localparam int ADDR_MSB = 7;
   localparam int ADDR_LSB = 4;
   localparam int DATA_MSB = 3;
   localparam int DATA_LSB = 0;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_LOAD  = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_OR    = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_NOT   = 4'h8;
   localparam logic [3:0] OP_SHL   = 4'h9;
   localparam logic [3:0] OP_SHR   = 4'hA;
   localparam logic [3:0] OP_JMP   = 4'hC;
   localparam logic [3:0] OP_JZ    = 4'hD;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [3:0] DP_IDLE  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_HALTED,
      ST_PAUSE
   } seq_state_e;

   // Opcodes that go out to the datapath; everything else resolves locally.
   function automatic logic is_dp_op(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_STORE, OP_LOAD, OP_AND,
         OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mini_cpu_prog_mem.sv
// Instruction store: synchronous write port for the host, registered read
// port for the sequencer fetch. Contents are never cleared by reset.
module mini_cpu_prog_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 12,
   parameter int AW    = 4
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mini_cpu_sequencer.sv
// Program sequencer for the 4-bit mini-CPU: fetch/decode, local control flow,
// timed datapath drive. Optional single-step mode under SEQ_SINGLE_STEP_EN.
//
// state     | meaning
// IDLE      | waiting for start after reset
// FETCH     | registered read of mem[pc]
// DECODE    | resolve JMP/JZ/NOP/HALT locally or load datapath regs
// EXEC      | hold datapath instruction for HOLD_CYCLES cycles
// HALTED    | stopped by HALT or halt request; start restarts at pc 0
// PAUSE     | single-step wait between instructions (step mode only)
module mini_cpu_sequencer
   import mini_cpu_pkg::*;
#(
   parameter int HOLD_CYCLES = 3,
   parameter int PROG_DEPTH  = 16,
   parameter int INSTR_W     = 12
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               prog_we_i,
   input  logic [PC_W-1:0]    prog_addr_i,
   input  logic [INSTR_W-1:0] prog_wdata_i,
   input  logic               start_i,
   input  logic               halt_req_i,
   input  logic [3:0]         acc_in_i,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic               step_mode_i,
   input  logic               step_i,
`endif
   output logic [3:0]         dp_opcode_o,
   output logic [3:0]         dp_addr_o,
   output logic [3:0]         dp_data_o,
   output logic               dp_we_o,
   output logic [PC_W-1:0]    pc_o,
   output logic               busy_o,
   output logic               halted_o
);

   localparam int CNT_W = $clog2(HOLD_CYCLES);

   seq_state_e          state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                halt_q, halt_d;
   logic [3:0]          dp_opcode_q, dp_opcode_d;
   logic [3:0]          dp_addr_q, dp_addr_d;
   logic [3:0]          dp_data_q, dp_data_d;
   logic                dp_we_q, dp_we_d;

   logic [INSTR_W-1:0]  instr;
   logic [3:0]          op, fld_addr, fld_data;
   logic                step_mode_w, step_w;
   logic                busy, mem_we;
   seq_state_e          boundary_state;

`ifdef SEQ_SINGLE_STEP_EN
   assign step_mode_w = step_mode_i;
   assign step_w      = step_i;
`else
   assign step_mode_w = 1'b0;
   assign step_w      = 1'b0;
`endif

   assign mem_we = prog_we_i & ~busy;

   mini_cpu_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .WIDTH (INSTR_W),
      .AW    (PC_W)
   ) u_prog_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (prog_addr_i),
      .wdata_i (prog_wdata_i),
      .re_i    (state_q == ST_FETCH),
      .raddr_i (pc_q),
      .rdata_o (instr)
   );

   assign op       = instr[OP_MSB:OP_LSB];
   assign fld_addr = instr[ADDR_MSB:ADDR_LSB];
   assign fld_data = instr[DATA_MSB:DATA_LSB];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         cnt_q       <= '0;
         halt_q      <= 1'b0;
         dp_opcode_q <= DP_IDLE;
         dp_addr_q   <= '0;
         dp_data_q   <= '0;
         dp_we_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         halt_q      <= halt_d;
         dp_opcode_q <= dp_opcode_d;
         dp_addr_q   <= dp_addr_d;
         dp_data_q   <= dp_data_d;
         dp_we_q     <= dp_we_d;
      end
   end

   // A pending halt wins over a single-step pause at an instruction boundary.
   always_comb begin
      if (halt_q || halt_req_i) begin
         boundary_state = ST_HALTED;
      end else if (step_mode_w) begin
         boundary_state = ST_PAUSE;
      end else begin
         boundary_state = ST_FETCH;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      halt_d      = halt_q;
      dp_opcode_d = dp_opcode_q;
      dp_addr_d   = dp_addr_q;
      dp_data_d   = dp_data_q;
      dp_we_d     = dp_we_q;
      case (state_q)
         ST_IDLE, ST_PAUSE: begin
            if (start_i && !halt_req_i) begin
               pc_d    = '0;
               halt_d  = 1'b0;
               state_d = ST_FETCH;
            end else if (state_q == ST_PAUSE && step_w && !halt_req_i) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (halt_req_i) halt_d = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (halt_req_i) halt_d = 1'b1;
            if (op == OP_HALT) begin
               state_d = ST_HALTED;
            end else if (is_dp_op(op)) begin
               dp_opcode_d = op;
               dp_addr_d   = fld_addr;
               dp_data_d   = fld_data;
               dp_we_d     = (op == OP_STORE);
               cnt_d       = CNT_W'(HOLD_CYCLES - 1);
               state_d     = ST_EXEC;
            end else begin
               if (op == OP_JMP || (op == OP_JZ && acc_in_i == 4'h0)) begin
                  pc_d = fld_addr;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
               state_d = boundary_state;
            end
         end
         ST_EXEC: begin
            if (halt_req_i) halt_d = 1'b1;
            if (cnt_q == '0) begin
               dp_opcode_d = DP_IDLE;
               dp_we_d     = 1'b0;
               pc_d        = pc_q + PC_W'(1);
               state_d     = boundary_state;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HALTED: begin
            if (start_i) begin
               pc_d    = '0;
               halt_d  = 1'b0;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
      halted_o = (state_q == ST_HALTED);
   end

   assign busy_o      = busy;
   assign pc_o        = pc_q;
   assign dp_opcode_o = dp_opcode_q;
   assign dp_addr_o   = dp_addr_q;
   assign dp_data_o   = dp_data_q;
   assign dp_we_o     = dp_we_q;

endmodule
